lab3_cache_mem_port: RTL and testbench
======================================

Name: lab3_cache_mem_port

Overview:
Memory-side port stage sitting directly downstream of the blocking cache controller's cache_req/cache_resp interface and upstream of main memory. It buffers word-granular spill (write) and refill (read) requests in a small request queue, tags each with an in-order opaque ID, and limits in-flight requests with credits. Responses are returned to the cache through a response queue that is sized so memory is never back-pressured. It also provides an idle indication so the controller can complete a flush.

Parameters:
REQ_DEPTH, 2, request queue entries (power of two, >=2)
RESP_DEPTH, 4, response queue entries and total credit count (power of two, >=2)
OPQ_W, 8, opaque tag width

Ports:
clk  in  1  clock, all flops rising-edge
reset_n  in  1  asynchronous active-low reset
cache_req_val  in  1  cache request valid
cache_req_rdy  out  1  request queue not full
cache_req_type  in  1  0=read (refill), 1=write (spill)
cache_req_addr  in  32  word address
cache_req_data  in  32  write data (ignored for reads)
cache_resp_val  out  1  response queue not empty
cache_resp_rdy  in  1  cache accepts response
cache_resp_type  out  1  type of returned response
cache_resp_data  out  32  read data (0 for writes)
mem_req_val  out  1  memory request valid
mem_req_rdy  in  1  memory accepts request
mem_req_type  out  1  forwarded type
mem_req_opaque  out  OPQ_W  issue tag
mem_req_addr  out  32  forwarded address
mem_req_data  out  32  forwarded data
mem_resp_val  in  1  memory response valid
mem_resp_rdy  out  1  constant 1 after reset
mem_resp_type  in  1  response type
mem_resp_opaque  in  OPQ_W  response tag
mem_resp_data  in  32  response data
idle  out  1  no request queued, none in flight, response queue empty
tag_err  out  1  sticky mismatch flag

Behaviour:
- Reset (reset_n=0, async): queues empty, pointers 0, issue_tag=0, expect_tag=0, credits=RESP_DEPTH, tag_err=0. Outputs while in reset: cache_req_rdy=0, cache_resp_val=0, mem_req_val=0, mem_resp_rdy=0, idle=0. From the first cycle after deassertion: cache_req_rdy=1, mem_resp_rdy=1, idle=1.
- Reset asserted mid-operation: all queued and in-flight state is discarded. Late memory responses that arrive after reset with mismatched tags set tag_err.
- Request queue: normal (non-bypass) FIFO. Enqueue on cache_req_val&&cache_req_rdy. cache_req_rdy = !full. Minimum latency from cache request to mem_req_val is 1 cycle.
- Issue: mem_req_val = !req_empty && credits!=0. Fields come from the queue head, with mem_req_opaque=issue_tag. On mem_req_val&&mem_req_rdy: dequeue, issue_tag++ (wraps modulo 2^OPQ_W), credits--.
- Credit return: credits++ on cache_resp_val&&cache_resp_rdy. Issue and return in the same cycle leave the count unchanged. Credits never exceed RESP_DEPTH and never go below 0.
- Response capture: on mem_resp_val, enqueue {type,data} into the response queue. The credits guarantee the queue is not full; an assertion checks this. If mem_resp_opaque != expect_tag, set tag_err=1 (sticky until reset) and still enqueue. expect_tag++ with wrap. Responses are in order.
- cache_resp_val = !resp_empty. cache_resp_type and cache_resp_data come from the head. Write responses carry data 0. Minimum latency from memory response to cache_resp_val is 1 cycle; there is no combinational mem_resp-to-cache_resp path.
- Simultaneous events: enqueue and dequeue on a full request queue are not allowed (rdy=0 when full). On an empty response queue, the same-cycle memory response is not visible until the next cycle.
- idle = req_empty && credits==RESP_DEPTH. This implies the response queue is empty and nothing is outstanding. The controller ANDs idle into flush_done.
- Width rules: pointers are log2(depth) bits plus a wrap bit for full/empty. Credits are log2(RESP_DEPTH)+1 bits.

Decomposition:
- Shared package lab3_cache_mem_port_pkg: req/resp type constants (TYPE_READ=0, TYPE_WRITE=1), packed struct mem_req_t {type, opaque, addr, data} and mem_resp_t {type, opaque, data}.
- One sub-module, lab3_cache_mem_port_fifo (parameterised width/depth, registered normal FIFO), instantiated twice.
- Credit counter, tag counters and tag check live in the top.

Test Plan:
- Single refill: read addr 0x1000, memory returns data 0xDEADBEEF with tag 0 after 3 cycles -> mem_req_opaque=0 one cycle after enqueue; cache_resp_data=0xDEADBEEF, type=0; idle returns to 1.
- Spill then refill burst: 4 writes then 4 reads with mem_req_rdy=1 -> tags 0..7 in order; write responses have data=0; order is preserved.
- Credit stall: cache_resp_rdy=0, issue 6 reads with RESP_DEPTH=4 -> exactly 4 mem_req handshakes; the 5th request is held until one cache response is popped; cache_req_rdy=0 once the request queue holds 2.
- Tag wrap: OPQ_W=2, 6 sequential reads -> tags 0,1,2,3,0,1; tag_err stays 0.
- Tag mismatch: memory returns tag 1 while expecting 0 -> tag_err=1 stays sticky and data is still delivered.
- Async reset mid-flight: drop reset_n between clock edges with 2 requests outstanding -> outputs go to their reset values immediately; after release idle=1 and credits=4.

Source files
------------

// File: rtl/lab3_cache_mem_port_pkg.sv
// Shared types for the cache memory-side port: request/response type codes,
// memory interface structs and the queue entry layouts.
package lab3_cache_mem_port_pkg;

  localparam logic TYPE_READ  = 1'b0;
  localparam logic TYPE_WRITE = 1'b1;

  // Opaque field sized for the widest tag the port is built with.
  localparam int OPQ_MAX_W = 16;

  typedef struct packed {
    logic                 typ;
    logic [OPQ_MAX_W-1:0] opaque;
    logic [31:0]          addr;
    logic [31:0]          data;
  } mem_req_t;

  typedef struct packed {
    logic                 typ;
    logic [OPQ_MAX_W-1:0] opaque;
    logic [31:0]          data;
  } mem_resp_t;

  // Tags are attached at issue, so the queues only hold the payload.
  typedef struct packed {
    logic        typ;
    logic [31:0] addr;
    logic [31:0] data;
  } req_entry_t;

  typedef struct packed {
    logic        typ;
    logic [31:0] data;
  } resp_entry_t;

endpackage

// File: rtl/lab3_cache_mem_port_fifo.sv
// Registered (non-bypass) FIFO; pointers carry an extra wrap bit so full and
// empty are distinguished without a separate count.
module lab3_cache_mem_port_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enq_val,
  input  logic [WIDTH-1:0] enq_data,
  input  logic             deq_val,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_enq, do_deq;

  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign do_enq    = enq_val && !full;
  assign do_deq    = deq_val && !empty;
  assign head_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_enq) begin
      mem_d[wr_ptr_q[AW-1:0]] = enq_data;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (do_deq) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/lab3_cache_mem_port.sv
// Memory-side port of the blocking cache: queues spill/refill requests, tags
// them in order, meters them with credits and returns responses to the cache.
module lab3_cache_mem_port
  import lab3_cache_mem_port_pkg::*;
#(
  parameter int REQ_DEPTH  = 2,
  parameter int RESP_DEPTH = 4,
  parameter int OPQ_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cache_req_val,
  output logic             cache_req_rdy,
  input  logic             cache_req_type,
  input  logic [31:0]      cache_req_addr,
  input  logic [31:0]      cache_req_data,
  output logic             cache_resp_val,
  input  logic             cache_resp_rdy,
  output logic             cache_resp_type,
  output logic [31:0]      cache_resp_data,
  output logic             mem_req_val,
  input  logic             mem_req_rdy,
  output logic             mem_req_type,
  output logic [OPQ_W-1:0] mem_req_opaque,
  output logic [31:0]      mem_req_addr,
  output logic [31:0]      mem_req_data,
  input  logic             mem_resp_val,
  output logic             mem_resp_rdy,
  input  logic             mem_resp_type,
  input  logic [OPQ_W-1:0] mem_resp_opaque,
  input  logic [31:0]      mem_resp_data,
  output logic             idle,
  output logic             tag_err
);

  localparam int CW = $clog2(RESP_DEPTH) + 1;
  localparam logic [CW-1:0]    CREDIT_MAX = CW'(RESP_DEPTH);
  localparam logic [CW-1:0]    CREDIT_ONE = CW'(1);
  localparam logic [OPQ_W-1:0] TAG_ONE    = OPQ_W'(1);

  // active_q holds the handshake outputs low until the first edge after reset.
  logic             active_q, active_d;
  logic [CW-1:0]    credits_q, credits_d;
  logic [OPQ_W-1:0] issue_tag_q, issue_tag_d;
  logic [OPQ_W-1:0] expect_tag_q, expect_tag_d;
  logic             tag_err_q, tag_err_d;

  req_entry_t  req_in, req_head;
  resp_entry_t resp_in, resp_head;
  logic        req_full, req_empty, resp_full, resp_empty;
  logic        req_fire, issue_fire, resp_capture, resp_pop;

  assign req_in   = '{typ: cache_req_type, addr: cache_req_addr, data: cache_req_data};
  assign req_fire = cache_req_val && cache_req_rdy;

  lab3_cache_mem_port_fifo #(
    .WIDTH($bits(req_entry_t)),
    .DEPTH(REQ_DEPTH)
  ) u_req_q (
    .clk      (clk),
    .reset_n  (reset_n),
    .enq_val  (req_fire),
    .enq_data (req_in),
    .deq_val  (issue_fire),
    .full     (req_full),
    .empty    (req_empty),
    .head_data(req_head)
  );

  // Write responses are returned with zero data regardless of what memory sends.
  assign resp_in      = '{typ:  mem_resp_type,
                          data: (mem_resp_type == TYPE_WRITE) ? 32'd0 : mem_resp_data};
  assign resp_capture = mem_resp_val && active_q;
  assign resp_pop     = cache_resp_val && cache_resp_rdy;

  lab3_cache_mem_port_fifo #(
    .WIDTH($bits(resp_entry_t)),
    .DEPTH(RESP_DEPTH)
  ) u_resp_q (
    .clk      (clk),
    .reset_n  (reset_n),
    .enq_val  (resp_capture),
    .enq_data (resp_in),
    .deq_val  (resp_pop),
    .full     (resp_full),
    .empty    (resp_empty),
    .head_data(resp_head)
  );

  assign mem_req_val     = !req_empty && (credits_q != '0);
  assign issue_fire      = mem_req_val && mem_req_rdy;
  assign mem_req_type    = req_head.typ;
  assign mem_req_addr    = req_head.addr;
  assign mem_req_data    = req_head.data;
  assign mem_req_opaque  = issue_tag_q;

  assign cache_req_rdy   = active_q && !req_full;
  assign mem_resp_rdy    = active_q;
  assign cache_resp_val  = !resp_empty;
  assign cache_resp_type = resp_head.typ;
  assign cache_resp_data = resp_head.data;
  assign idle            = active_q && req_empty && (credits_q == CREDIT_MAX);
  assign tag_err         = tag_err_q;

  always_comb begin
    active_d     = 1'b1;
    credits_d    = credits_q;
    issue_tag_d  = issue_tag_q;
    expect_tag_d = expect_tag_q;
    tag_err_d    = tag_err_q;
    case ({issue_fire, resp_pop})
      2'b10:   credits_d = credits_q - CREDIT_ONE;
      2'b01:   credits_d = credits_q + CREDIT_ONE;
      default: credits_d = credits_q;
    endcase
    if (issue_fire) begin
      issue_tag_d = issue_tag_q + TAG_ONE;
    end
    if (resp_capture) begin
      expect_tag_d = expect_tag_q + TAG_ONE;
      if (mem_resp_opaque != expect_tag_q) begin
        tag_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_q     <= 1'b0;
      credits_q    <= CREDIT_MAX;
      issue_tag_q  <= '0;
      expect_tag_q <= '0;
      tag_err_q    <= 1'b0;
    end else begin
      active_q     <= active_d;
      credits_q    <= credits_d;
      issue_tag_q  <= issue_tag_d;
      expect_tag_q <= expect_tag_d;
      tag_err_q    <= tag_err_d;
    end
  end

  // Credits bound the outstanding responses to the response queue depth.
  assert property (@(posedge clk) disable iff (!reset_n) resp_capture |-> !resp_full);

endmodule

// File: tb/tb_lab3_cache_mem_port.sv
// Directed bench for lab3_cache_mem_port built with a 2-bit tag so wrap is
// exercised; expected tags are tracked modulo 4.
module tb_lab3_cache_mem_port;

  localparam int OPQ_W = 2;
  localparam int TAGS  = 4;

  logic             clk, reset_n;
  logic             cache_req_val, cache_req_rdy, cache_req_type;
  logic [31:0]      cache_req_addr, cache_req_data;
  logic             cache_resp_val, cache_resp_rdy, cache_resp_type;
  logic [31:0]      cache_resp_data;
  logic             mem_req_val, mem_req_rdy, mem_req_type;
  logic [OPQ_W-1:0] mem_req_opaque;
  logic [31:0]      mem_req_addr, mem_req_data;
  logic             mem_resp_val, mem_resp_rdy, mem_resp_type;
  logic [OPQ_W-1:0] mem_resp_opaque;
  logic [31:0]      mem_resp_data;
  logic             idle, tag_err;

  int n_checks = 0;
  int n_fail   = 0;
  int itag     = 0;
  int etag     = 0;
  logic pend_type[$];

  lab3_cache_mem_port #(.REQ_DEPTH(2), .RESP_DEPTH(4), .OPQ_W(OPQ_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .cache_req_val(cache_req_val), .cache_req_rdy(cache_req_rdy),
    .cache_req_type(cache_req_type), .cache_req_addr(cache_req_addr),
    .cache_req_data(cache_req_data),
    .cache_resp_val(cache_resp_val), .cache_resp_rdy(cache_resp_rdy),
    .cache_resp_type(cache_resp_type), .cache_resp_data(cache_resp_data),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy),
    .mem_req_type(mem_req_type), .mem_req_opaque(mem_req_opaque),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy),
    .mem_resp_type(mem_resp_type), .mem_resp_opaque(mem_resp_opaque),
    .mem_resp_data(mem_resp_data),
    .idle(idle), .tag_err(tag_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic quiet_inputs();
    cache_req_val   = 1'b0;
    cache_req_type  = 1'b0;
    cache_req_addr  = '0;
    cache_req_data  = '0;
    cache_resp_rdy  = 1'b1;
    mem_req_rdy     = 1'b1;
    mem_resp_val    = 1'b0;
    mem_resp_type   = 1'b0;
    mem_resp_opaque = '0;
    mem_resp_data   = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    quiet_inputs();
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    itag = 0;
    etag = 0;
    pend_type.delete();
    @(negedge clk);
  endtask

  // Plays memory and cache until everything outstanding has returned.
  task automatic drain(input int max_cycles);
    int  c = 0;
    bit  done = 0;
    cache_req_val  = 1'b0;
    cache_resp_rdy = 1'b1;
    mem_req_rdy    = 1'b1;
    while (!done && c < max_cycles) begin
      @(negedge clk);
      c++;
      if (idle && pend_type.size() == 0) begin
        done = 1;
        mem_resp_val = 1'b0;
      end else begin
        if (pend_type.size() > 0) begin
          mem_resp_val    = 1'b1;
          mem_resp_type   = pend_type.pop_front();
          mem_resp_opaque = OPQ_W'(etag);
          mem_resp_data   = 32'h0D0D_0000;
          etag = (etag + 1) % TAGS;
        end else begin
          mem_resp_val = 1'b0;
        end
        if (mem_req_val) begin
          pend_type.push_back(mem_req_type);
          itag = (itag + 1) % TAGS;
        end
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain_timeout: idle=%0b after %0d cycles, required 1", idle, c);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (cache_req_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_req_rdy: got %b exp 0", cache_req_rdy); end
    n_checks++; if (cache_resp_val !== 1'b0) begin n_fail++; $display("FAIL rst_resp_val: got %b exp 0", cache_resp_val); end
    n_checks++; if (mem_req_val !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req_val: got %b exp 0", mem_req_val); end
    n_checks++; if (mem_resp_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_mem_resp_rdy: got %b exp 0", mem_resp_rdy); end
    n_checks++; if (idle !== 1'b0) begin n_fail++; $display("FAIL rst_idle: got %b exp 0", idle); end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (cache_req_rdy !== 1'b1) begin n_fail++; $display("FAIL post_rst_req_rdy: got %b exp 1", cache_req_rdy); end
    n_checks++; if (mem_resp_rdy !== 1'b1) begin n_fail++; $display("FAIL post_rst_mem_resp_rdy: got %b exp 1", mem_resp_rdy); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL post_rst_idle: got %b exp 1", idle); end
    n_checks++; if (tag_err !== 1'b0) begin n_fail++; $display("FAIL post_rst_tag_err: got %b exp 0", tag_err); end
  endtask

  task automatic test_single_refill();
    cache_req_val  = 1'b1;
    cache_req_type = 1'b0;
    cache_req_addr = 32'h0000_1000;
    cache_req_data = 32'h0;
    @(negedge clk);
    cache_req_val = 1'b0;
    n_checks++; if (mem_req_val !== 1'b1) begin n_fail++; $display("FAIL refill_issue_val: got %b exp 1", mem_req_val); end
    n_checks++; if (mem_req_opaque !== 2'd0) begin n_fail++; $display("FAIL refill_opaque: got %0d exp 0", mem_req_opaque); end
    n_checks++; if (mem_req_addr !== 32'h1000) begin n_fail++; $display("FAIL refill_addr: got %h exp 00001000", mem_req_addr); end
    n_checks++; if (mem_req_type !== 1'b0) begin n_fail++; $display("FAIL refill_type: got %b exp 0", mem_req_type); end
    itag = (itag + 1) % TAGS;
    @(negedge clk);
    n_checks++; if (mem_req_val !== 1'b0) begin n_fail++; $display("FAIL refill_issue_once: got %b exp 0", mem_req_val); end
    n_checks++; if (idle !== 1'b0) begin n_fail++; $display("FAIL refill_busy: idle got %b exp 0", idle); end
    @(negedge clk);
    @(negedge clk);
    mem_resp_val    = 1'b1;
    mem_resp_type   = 1'b0;
    mem_resp_opaque = 2'd0;
    mem_resp_data   = 32'hDEAD_BEEF;
    etag = (etag + 1) % TAGS;
    n_checks++; if (cache_resp_val !== 1'b0) begin n_fail++; $display("FAIL refill_no_bypass: got %b exp 0", cache_resp_val); end
    @(negedge clk);
    mem_resp_val = 1'b0;
    n_checks++; if (cache_resp_val !== 1'b1) begin n_fail++; $display("FAIL refill_resp_val: got %b exp 1", cache_resp_val); end
    n_checks++; if (cache_resp_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL refill_resp_data: got %h exp deadbeef", cache_resp_data); end
    n_checks++; if (cache_resp_type !== 1'b0) begin n_fail++; $display("FAIL refill_resp_type: got %b exp 0", cache_resp_type); end
    @(negedge clk);
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL refill_idle: got %b exp 1", idle); end
    n_checks++; if (cache_resp_val !== 1'b0) begin n_fail++; $display("FAIL refill_popped: got %b exp 0", cache_resp_val); end
  endtask

  task automatic run_group(input logic typ, input logic [31:0] abase);
    int seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mem_req_val) begin
        n_checks++; if (mem_req_opaque !== OPQ_W'(itag)) begin n_fail++; $display("FAIL burst_tag: got %0d exp %0d", mem_req_opaque, itag); end
        n_checks++; if (mem_req_type !== typ) begin n_fail++; $display("FAIL burst_type: got %b exp %b", mem_req_type, typ); end
        n_checks++; if (mem_req_addr !== abase + 32'(seen)) begin n_fail++; $display("FAIL burst_addr: got %h exp %h", mem_req_addr, abase + 32'(seen)); end
        n_checks++; if (mem_req_data !== 32'h5A00_0000 + 32'(seen)) begin n_fail++; $display("FAIL burst_data: got %h exp %h", mem_req_data, 32'h5A00_0000 + 32'(seen)); end
        itag = (itag + 1) % TAGS;
        seen++;
      end
      if (k < 4) begin
        n_checks++; if (cache_req_rdy !== 1'b1) begin n_fail++; $display("FAIL burst_req_rdy: got %b exp 1", cache_req_rdy); end
        cache_req_val  = 1'b1;
        cache_req_type = typ;
        cache_req_addr = abase + 32'(k);
        cache_req_data = 32'h5A00_0000 + 32'(k);
      end else begin
        cache_req_val = 1'b0;
      end
    end
    n_checks++; if (seen != 4) begin n_fail++; $display("FAIL burst_issue_count: got %0d exp 4", seen); end
  endtask

  task automatic respond_group(input logic typ);
    int got = 0;
    logic [31:0] exp_data;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      if (cache_resp_val) begin
        exp_data = (typ == 1'b1) ? 32'h0 : 32'hC0DE_0000 + 32'(got);
        n_checks++; if (cache_resp_type !== typ) begin n_fail++; $display("FAIL burst_resp_type: got %b exp %b", cache_resp_type, typ); end
        n_checks++; if (cache_resp_data !== exp_data) begin n_fail++; $display("FAIL burst_resp_data: got %h exp %h", cache_resp_data, exp_data); end
        got++;
      end
      if (j < 4) begin
        mem_resp_val    = 1'b1;
        mem_resp_type   = typ;
        mem_resp_opaque = OPQ_W'(etag);
        mem_resp_data   = (typ == 1'b1) ? 32'hFFFF_FFFF : 32'hC0DE_0000 + 32'(j);
        etag = (etag + 1) % TAGS;
      end else begin
        mem_resp_val = 1'b0;
      end
    end
    @(negedge clk);
    n_checks++; if (got != 4) begin n_fail++; $display("FAIL burst_resp_count: got %0d exp 4", got); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL burst_idle: got %b exp 1", idle); end
    n_checks++; if (tag_err !== 1'b0) begin n_fail++; $display("FAIL burst_tag_err: got %b exp 0", tag_err); end
  endtask

  task automatic test_back_to_back();
    run_group(1'b1, 32'h0000_2000);
    respond_group(1'b1);
    run_group(1'b0, 32'h0000_3000);
    respond_group(1'b0);
  endtask

  task automatic test_credit_stall();
    int sent = 0;
    int hs   = 0;
    cache_resp_rdy = 1'b0;
    mem_req_rdy    = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (mem_req_val) begin
        n_checks++; if (mem_req_opaque !== OPQ_W'(itag)) begin n_fail++; $display("FAIL stall_tag: got %0d exp %0d", mem_req_opaque, itag); end
        itag = (itag + 1) % TAGS;
        hs++;
      end
      if (sent < 6 && cache_req_rdy) begin
        cache_req_val  = 1'b1;
        cache_req_type = 1'b0;
        cache_req_addr = 32'h0000_4000 + 32'(sent);
        cache_req_data = 32'h5A00_0000 + 32'(sent);
        sent++;
      end else begin
        cache_req_val = 1'b0;
      end
    end
    n_checks++; if (hs != 4) begin n_fail++; $display("FAIL stall_handshakes: got %0d exp 4", hs); end
    n_checks++; if (sent != 6) begin n_fail++; $display("FAIL stall_accepted: got %0d exp 6", sent); end
    n_checks++; if (mem_req_val !== 1'b0) begin n_fail++; $display("FAIL stall_held: got %b exp 0", mem_req_val); end
    n_checks++; if (cache_req_rdy !== 1'b0) begin n_fail++; $display("FAIL stall_req_full: got %b exp 0", cache_req_rdy); end
    for (int j = 0; j < 4; j++) begin
      mem_resp_val    = 1'b1;
      mem_resp_type   = 1'b0;
      mem_resp_opaque = OPQ_W'(etag);
      mem_resp_data   = 32'h7700_0000 + 32'(j);
      etag = (etag + 1) % TAGS;
      @(negedge clk);
    end
    mem_resp_val = 1'b0;
    n_checks++; if (cache_resp_val !== 1'b1) begin n_fail++; $display("FAIL stall_resp_val: got %b exp 1", cache_resp_val); end
    n_checks++; if (mem_req_val !== 1'b0) begin n_fail++; $display("FAIL stall_no_credit: got %b exp 0", mem_req_val); end
    n_checks++; if (cache_resp_data !== 32'h7700_0000) begin n_fail++; $display("FAIL stall_resp_data: got %h exp 77000000", cache_resp_data); end
    cache_resp_rdy = 1'b1;
    @(negedge clk);
    cache_resp_rdy = 1'b0;
    n_checks++; if (mem_req_val !== 1'b1) begin n_fail++; $display("FAIL stall_release: got %b exp 1", mem_req_val); end
    n_checks++; if (mem_req_addr !== 32'h0000_4004) begin n_fail++; $display("FAIL stall_fifth_addr: got %h exp 00004004", mem_req_addr); end
    n_checks++; if (mem_req_opaque !== OPQ_W'(itag)) begin n_fail++; $display("FAIL stall_fifth_tag: got %0d exp %0d", mem_req_opaque, itag); end
    pend_type.push_back(mem_req_type);
    itag = (itag + 1) % TAGS;
    drain(60);
  endtask

  task automatic test_tag_wrap();
    logic [1:0] exp_tags [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      cache_req_val  = 1'b1;
      cache_req_type = 1'b0;
      cache_req_addr = 32'h0000_5000 + 32'(i);
      @(negedge clk);
      cache_req_val = 1'b0;
      n_checks++; if (!mem_req_val || mem_req_opaque !== exp_tags[i]) begin n_fail++; $display("FAIL wrap_tag[%0d]: got val=%b tag=%0d exp tag %0d", i, mem_req_val, mem_req_opaque, exp_tags[i]); end
      itag = (itag + 1) % TAGS;
      @(negedge clk);
      mem_resp_val    = 1'b1;
      mem_resp_type   = 1'b0;
      mem_resp_opaque = exp_tags[i];
      mem_resp_data   = 32'h6000_0000 + 32'(i);
      etag = (etag + 1) % TAGS;
      @(negedge clk);
      mem_resp_val = 1'b0;
      n_checks++; if (cache_resp_data !== 32'h6000_0000 + 32'(i)) begin n_fail++; $display("FAIL wrap_data[%0d]: got %h exp %h", i, cache_resp_data, 32'h6000_0000 + 32'(i)); end
    end
    @(negedge clk);
    n_checks++; if (tag_err !== 1'b0) begin n_fail++; $display("FAIL wrap_tag_err: got %b exp 0", tag_err); end
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL wrap_idle: got %b exp 1", idle); end
  endtask

  task automatic test_tag_mismatch();
    for (int t = 0; t < 2; t++) begin
      cache_req_val  = 1'b1;
      cache_req_type = 1'b0;
      cache_req_addr = 32'h0000_6000 + 32'(t);
      @(negedge clk);
      cache_req_val = 1'b0;
      n_checks++; if (mem_req_opaque !== OPQ_W'(itag)) begin n_fail++; $display("FAIL mism_issue_tag: got %0d exp %0d", mem_req_opaque, itag); end
      itag = (itag + 1) % TAGS;
      @(negedge clk);
      mem_resp_val    = 1'b1;
      mem_resp_type   = 1'b0;
      mem_resp_opaque = (t == 0) ? OPQ_W'(etag + 1) : OPQ_W'(etag);
      mem_resp_data   = 32'hBAD0_0000 + 32'(t);
      etag = (etag + 1) % TAGS;
      @(negedge clk);
      mem_resp_val = 1'b0;
      n_checks++; if (tag_err !== 1'b1) begin n_fail++; $display("FAIL mism_tag_err[%0d]: got %b exp 1", t, tag_err); end
      n_checks++; if (cache_resp_val !== 1'b1 || cache_resp_data !== 32'hBAD0_0000 + 32'(t)) begin n_fail++; $display("FAIL mism_data[%0d]: got val=%b data=%h exp %h", t, cache_resp_val, cache_resp_data, 32'hBAD0_0000 + 32'(t)); end
      @(negedge clk);
    end
    n_checks++; if (tag_err !== 1'b1) begin n_fail++; $display("FAIL mism_sticky: got %b exp 1", tag_err); end
  endtask

  task automatic test_async_reset();
    cache_req_type = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cache_req_val  = 1'b1;
      cache_req_addr = 32'h0000_7000 + 32'(i);
      @(negedge clk);
    end
    cache_req_val = 1'b0;
    mem_req_rdy   = 1'b0;
    n_checks++; if (mem_req_val !== 1'b1) begin n_fail++; $display("FAIL arst_pre_val: got %b exp 1", mem_req_val); end
    n_checks++; if (idle !== 1'b0) begin n_fail++; $display("FAIL arst_pre_idle: got %b exp 0", idle); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (mem_req_val !== 1'b0) begin n_fail++; $display("FAIL arst_mem_req_val: got %b exp 0", mem_req_val); end
    n_checks++; if (cache_req_rdy !== 1'b0) begin n_fail++; $display("FAIL arst_req_rdy: got %b exp 0", cache_req_rdy); end
    n_checks++; if (mem_resp_rdy !== 1'b0) begin n_fail++; $display("FAIL arst_mem_resp_rdy: got %b exp 0", mem_resp_rdy); end
    n_checks++; if (idle !== 1'b0) begin n_fail++; $display("FAIL arst_idle: got %b exp 0", idle); end
    n_checks++; if (tag_err !== 1'b0) begin n_fail++; $display("FAIL arst_tag_err: got %b exp 0", tag_err); end
    @(negedge clk);
    quiet_inputs();
    reset_n = 1'b1;
    itag = 0;
    etag = 0;
    pend_type.delete();
    @(negedge clk);
    n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL arst_post_idle: got %b exp 1", idle); end
    n_checks++; if (mem_req_val !== 1'b0) begin n_fail++; $display("FAIL arst_post_req_val: got %b exp 0", mem_req_val); end
    n_checks++; if (cache_resp_val !== 1'b0) begin n_fail++; $display("FAIL arst_post_resp_val: got %b exp 0", cache_resp_val); end
    cache_req_val  = 1'b1;
    cache_req_addr = 32'h0000_8000;
    @(negedge clk);
    cache_req_val = 1'b0;
    n_checks++; if (mem_req_opaque !== 2'd0 || mem_req_addr !== 32'h8000) begin n_fail++; $display("FAIL arst_fresh_req: got tag=%0d addr=%h exp tag 0 addr 00008000", mem_req_opaque, mem_req_addr); end
    pend_type.push_back(mem_req_type);
    itag = 1;
    drain(20);
    n_checks++; if (tag_err !== 1'b0) begin n_fail++; $display("FAIL arst_fresh_tag_err: got %b exp 0", tag_err); end
  endtask

  initial begin
    reset_n = 1'b0;
    quiet_inputs();
    test_reset();
    test_single_refill();
    test_back_to_back();
    test_credit_stall();
    test_tag_wrap();
    test_tag_mismatch();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
